uart_rx_cfg: RTL and testbench

- Next-generation parametrised UART receiver, successor to the fixed 8N1 receiver inside Uart8.
- Adds configurable data width, optional odd/even parity, 1 or 2 stop bits, 16x oversampling with majority vote, false-start rejection, break detection and separate error flags.
- Sits between the board rx pin and the byte consumer; replaces the receive half of Uart8 in new designs.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receiver and the matching transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rxState_e;

    function automatic int unsigned calc_div(int unsigned clock, int unsigned baud);
        return clock / (baud * OVERSAMPLE);
    endfunction

    function automatic logic maj3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with a synchronous phase clear.
module uart_baud_tick #(
    parameter int unsigned DIV = 78
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling with 3-sample majority vote,
// optional parity, 1/2 stop bits, false-start rejection and break detection.
module uart_rx_cfg #(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic [DATA_BITS-1:0] rxOut,
    output logic                 rxParityErr,
    output logic                 rxFrameErr,
    output logic                 rxBreak,
    output logic                 rxErr
);
    import uart_pkg::*;

    localparam int unsigned   DIV       = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam parity_e       PAR_MODE  = parity_e'(PARITY[1:0]);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (OVERSAMPLE != 16) begin : gBadOversample
        $error("uart_rx_cfg: OVERSAMPLE must be 16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : gBadParity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DIV < 1) begin : gBadDiv
        $error("uart_rx_cfg: CLOCK_RATE too low for BAUD_RATE*16");
    end

    logic sync1, line;
    logic tick, divClear;

    rxState_e             state, stateN;
    logic [3:0]           sCnt, sCntN;
    logic [3:0]           idx, idxN;
    logic [DATA_BITS-1:0] shiftReg, shiftN;
    logic [1:0]           samp, sampN;
    logic                 bitVal, bitValN;
    logic                 parBit, parBitN;
    logic                 stopLow, stopLowN;
    logic                 frameC, frameCN;
    logic [DATA_BITS-1:0] outN;
    logic                 doneN, parErrN, frameErrN, breakN;

    logic majNow, dataParity, parErr, firstStopLow, isBreak;

    uart_baud_tick #(.DIV(DIV)) uTick (
        .clk   (clk),
        .reset (reset),
        .clear (divClear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= rxIn;
            line  <= sync1;
        end
    end

    assign majNow       = maj3(samp[0], samp[1], line);
    assign dataParity   = (^shiftReg) ^ parBit;
    assign parErr       = (PAR_MODE == PAR_EVEN) ? dataParity :
                          (PAR_MODE == PAR_ODD)  ? ~dataParity : 1'b0;
    // With one stop bit the first stop is the one being sampled right now.
    assign firstStopLow = (idx == 4'd0) ? ~majNow : stopLow;
    assign isBreak      = (shiftReg == '0) && (PAR_MODE == PAR_NONE || !parBit) && firstStopLow;

    always_comb begin
        stateN    = state;
        sCntN     = sCnt;
        idxN      = idx;
        shiftN    = shiftReg;
        sampN     = samp;
        bitValN   = bitVal;
        parBitN   = parBit;
        stopLowN  = stopLow;
        frameCN   = frameC;
        outN      = rxOut;
        doneN     = 1'b0;
        parErrN   = rxParityErr;
        frameErrN = rxFrameErr;
        breakN    = rxBreak;
        divClear  = 1'b0;

        unique case (state)
            IDLE: begin
                sCntN = '0;
                idxN  = '0;
                if (rxEn && !line) begin
                    stateN   = START;
                    divClear = 1'b1;
                    frameCN  = 1'b0;
                    stopLowN = 1'b0;
                    parBitN  = 1'b0;
                end
            end
            BREAK_WAIT: begin
                if (tick) begin
                    if (!line) begin
                        sCntN = '0;
                    end else if (sCnt == 4'd15) begin
                        stateN = IDLE;
                        sCntN  = '0;
                    end else begin
                        sCntN = sCnt + 4'd1;
                    end
                end
            end
            START, DATA, uart_pkg::PARITY, STOP: begin
                if (tick) begin
                    sCntN = sCnt + 4'd1;
                    if (sCnt == 4'd7) sampN[0] = line;
                    if (sCnt == 4'd8) sampN[1] = line;
                    if (sCnt == 4'd9) bitValN = majNow;
                    if (sCnt == 4'd15) begin
                        if (state == START) begin
                            stateN = bitVal ? IDLE : DATA;
                            idxN   = '0;
                        end else if (state == DATA) begin
                            shiftN = {bitVal, shiftReg[DATA_BITS-1:1]};
                            if (idx == DATA_LAST) begin
                                idxN   = '0;
                                stateN = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
                            end else begin
                                idxN = idx + 4'd1;
                            end
                        end else if (state == uart_pkg::PARITY) begin
                            parBitN = bitVal;
                            idxN    = '0;
                            stateN  = STOP;
                        end else begin
                            idxN = idx + 4'd1;
                        end
                    end
                    // Frame completes at the last stop bit's centre, not its end,
                    // so a start bit immediately following is still caught.
                    if (state == STOP && sCnt == 4'd9) begin
                        frameCN = frameC | ~majNow;
                        if (idx == 4'd0) stopLowN = ~majNow;
                        if (idx == STOP_LAST) begin
                            outN      = shiftReg;
                            doneN     = 1'b1;
                            parErrN   = parErr;
                            frameErrN = frameC | ~majNow;
                            breakN    = isBreak;
                            stateN    = isBreak ? BREAK_WAIT : IDLE;
                            sCntN     = '0;
                        end
                    end
                end
            end
            default: stateN = IDLE;
        endcase

        if (!rxEn) begin
            stateN    = IDLE;
            sCntN     = '0;
            idxN      = '0;
            outN      = rxOut;
            doneN     = 1'b0;
            parErrN   = rxParityErr;
            frameErrN = rxFrameErr;
            breakN    = rxBreak;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sCnt        <= '0;
            idx         <= '0;
            shiftReg    <= '0;
            samp        <= '0;
            bitVal      <= 1'b0;
            parBit      <= 1'b0;
            stopLow     <= 1'b0;
            frameC      <= 1'b0;
            rxOut       <= '0;
            rxDone      <= 1'b0;
            rxParityErr <= 1'b0;
            rxFrameErr  <= 1'b0;
            rxBreak     <= 1'b0;
        end else begin
            state       <= stateN;
            sCnt        <= sCntN;
            idx         <= idxN;
            shiftReg    <= shiftN;
            samp        <= sampN;
            bitVal      <= bitValN;
            parBit      <= parBitN;
            stopLow     <= stopLowN;
            frameC      <= frameCN;
            rxOut       <= outN;
            rxDone      <= doneN;
            rxParityErr <= parErrN;
            rxFrameErr  <= frameErrN;
            rxBreak     <= breakN;
        end
    end

    assign rxBusy = (state == START) || (state == DATA) ||
                    (state == uart_pkg::PARITY) || (state == STOP);
    assign rxErr  = rxParityErr | rxFrameErr | rxBreak;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three line formats (8N1, 8E2, 9O1) against a frame-level model.
module tb_uart_rx_cfg;

    localparam int unsigned CLK_RATE = 1_228_800;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned BIT_CYC  = CLK_RATE / BAUD;
    localparam int unsigned TICK_CYC = BIT_CYC / 16;

    typedef struct {
        int          inst;
        int unsigned data;
        bit          perr;
        bit          ferr;
        bit          brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rxEn;
    logic [2:0] lineV;
    logic [2:0] doneV, busyV, perrV, ferrV, brkV, errV;
    logic [7:0] out0, out1;
    logic [8:0] out2;

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];
    exp_t lastE[3];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u8n1 (
        .clk(clk), .reset(reset), .rxEn(rxEn[0]), .rxIn(lineV[0]), .rxBusy(busyV[0]),
        .rxDone(doneV[0]), .rxOut(out0), .rxParityErr(perrV[0]), .rxFrameErr(ferrV[0]),
        .rxBreak(brkV[0]), .rxErr(errV[0]));

    uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .OVERSAMPLE(16)) u8e2 (
        .clk(clk), .reset(reset), .rxEn(rxEn[1]), .rxIn(lineV[1]), .rxBusy(busyV[1]),
        .rxDone(doneV[1]), .rxOut(out1), .rxParityErr(perrV[1]), .rxFrameErr(ferrV[1]),
        .rxBreak(brkV[1]), .rxErr(errV[1]));

    uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(9), .PARITY(1),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u9o1 (
        .clk(clk), .reset(reset), .rxEn(rxEn[2]), .rxIn(lineV[2]), .rxBusy(busyV[2]),
        .rxDone(doneV[2]), .rxOut(out2), .rxParityErr(perrV[2]), .rxFrameErr(ferrV[2]),
        .rxBreak(brkV[2]), .rxErr(errV[2]));

    function automatic int unsigned dataBits(int i);
        return (i == 2) ? 9 : 8;
    endfunction
    function automatic int unsigned parMode(int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int unsigned stopBits(int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int unsigned outOf(int i);
        return (i == 0) ? 32'(out0) : ((i == 1) ? 32'(out1) : 32'(out2));
    endfunction

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic holdLine(input int i, input bit lvl, input int unsigned cyc);
        lineV[i] = lvl;
        repeat (cyc) @(negedge clk);
    endtask

    // Builds the line waveform and the expected receive record for one frame.
    task automatic sendFrame(input int i, input int unsigned dIn, input bit badPar,
                             input bit [1:0] stopLvl, input bit lastShort);
        int unsigned n = dataBits(i);
        int unsigned d = dIn & ((32'd1 << n) - 1);
        bit          bits[$];
        bit          p = 1'b0;
        bit          anyLow = 1'b0;
        exp_t        e;
        bits.push_back(1'b0);
        for (int k = 0; k < int'(n); k++) bits.push_back(d[k]);
        if (parMode(i) != 0) begin
            p = (parMode(i) == 2) ? (^d) : (~^d);
            p = p ^ badPar;
            bits.push_back(p);
        end
        for (int k = 0; k < int'(stopBits(i)); k++) begin
            bits.push_back(stopLvl[k]);
            if (!stopLvl[k]) anyLow = 1'b1;
        end
        e.inst = i;
        e.data = d;
        e.perr = (parMode(i) != 0) && badPar;
        e.ferr = anyLow;
        e.brk  = (d == 0) && (parMode(i) == 0 || !p) && !stopLvl[0];
        expQ.push_back(e);
        for (int k = 0; k < bits.size(); k++) begin
            if (lastShort && k == bits.size() - 1) lineV[i] = bits[k];
            else holdLine(i, bits[k], BIT_CYC);
        end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned c = 0;
        while (expQ.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkVal("pendingFrames", expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (doneV[i]) begin
                checkVal("doneExpected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkVal("doneInst", i, e.inst);
                    checkVal("rxOut", outOf(i), e.data);
                    checkVal("rxParityErr", perrV[i], e.perr);
                    checkVal("rxFrameErr", ferrV[i], e.ferr);
                    checkVal("rxBreak", brkV[i], e.brk);
                    checkVal("rxErr", errV[i], e.perr | e.ferr | e.brk);
                    lastE[i] = e;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d7a;
        bit         found;
        int unsigned rd;
        bit          bad;
        bit [1:0]    stops;

        d7a   = 8'h7A;
        reset = 1'b0;
        rxEn  = '0;
        lineV = '1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkVal("rstBusy", busyV[i], 0);
            checkVal("rstDone", doneV[i], 0);
            checkVal("rstOut", outOf(i), 0);
            checkVal("rstErr", {perrV[i], ferrV[i], brkV[i], errV[i]}, 0);
        end
        reset = 1'b1;
        rxEn  = '1;
        repeat (2 * BIT_CYC) @(negedge clk);

        // 8N1 0x7A; busy must drop right with rxDone
        sendFrame(0, 32'h7A, 1'b0, 2'b11, 1'b1);
        found = 1'b0;
        for (int c = 0; c < int'(2 * BIT_CYC) && !found; c++) begin
            @(negedge clk);
            if (doneV[0]) found = 1'b1;
        end
        checkVal("t1DoneSeen", found, 1);
        repeat (2) @(negedge clk);
        checkVal("t1BusyAfterDone", busyV[0], 0);
        holdLine(0, 1'b1, 2 * BIT_CYC);
        drain(4 * BIT_CYC);

        // 8E2: bad parity on 0xB1, then good 0x3C clears the flag
        sendFrame(1, 32'hB1, 1'b1, 2'b11, 1'b0);
        holdLine(1, 1'b1, 2 * BIT_CYC);
        sendFrame(1, 32'h3C, 1'b0, 2'b11, 1'b0);
        holdLine(1, 1'b1, 2 * BIT_CYC);
        drain(4 * BIT_CYC);

        // 9-bit back-to-back frames
        sendFrame(2, 32'h1A5, 1'b0, 2'b11, 1'b0);
        sendFrame(2, 32'h05A, 1'b0, 2'b11, 1'b0);
        holdLine(2, 1'b1, 2 * BIT_CYC);
        drain(4 * BIT_CYC);

        // stop bit low on 0x55, then a short glitch that must be rejected
        sendFrame(0, 32'h55, 1'b0, 2'b00, 1'b0);
        holdLine(0, 1'b1, 3 * BIT_CYC);
        drain(4 * BIT_CYC);
        holdLine(0, 1'b0, 3 * TICK_CYC);
        checkVal("glitchBusy", busyV[0], 1);
        holdLine(0, 1'b1, BIT_CYC);
        checkVal("glitchRejected", busyV[0], 0);
        holdLine(0, 1'b1, BIT_CYC);

        // break: 12 low bit times, a short high then a low pulse must stay ignored
        expQ.push_back('{0, 0, 1'b0, 1'b1, 1'b1});
        holdLine(0, 1'b0, 11 * BIT_CYC);
        checkVal("breakWaitBusy", busyV[0], 0);
        holdLine(0, 1'b0, BIT_CYC);
        holdLine(0, 1'b1, BIT_CYC / 2);
        holdLine(0, 1'b0, BIT_CYC);
        holdLine(0, 1'b1, 2 * BIT_CYC);
        sendFrame(0, 32'hA5, 1'b0, 2'b11, 1'b0);
        holdLine(0, 1'b1, 2 * BIT_CYC);
        drain(4 * BIT_CYC);

        // randomized frames on every format
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                rd    = $urandom;
                bad   = (parMode(i) != 0) && ($urandom_range(0, 1) == 1);
                stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                sendFrame(i, rd, bad, stops, 1'b0);
                holdLine(i, 1'b1, 2 * BIT_CYC);
            end
        end
        drain(4 * BIT_CYC);

        // rxEn drop at data bit 4
        holdLine(0, 1'b0, BIT_CYC);
        for (int k = 0; k < 4; k++) holdLine(0, d7a[k], BIT_CYC);
        holdLine(0, d7a[4], BIT_CYC / 2);
        rxEn[0] = 1'b0;
        @(negedge clk);
        checkVal("enAbortBusy", busyV[0], 0);
        checkVal("enAbortOut", out0, lastE[0].data);
        checkVal("enAbortFlags", {perrV[0], ferrV[0], brkV[0]},
                 {lastE[0].perr, lastE[0].ferr, lastE[0].brk});
        holdLine(0, d7a[4], BIT_CYC / 2 - 1);
        for (int k = 5; k < 8; k++) holdLine(0, d7a[k], BIT_CYC);
        holdLine(0, 1'b1, 2 * BIT_CYC);
        rxEn[0] = 1'b1;
        holdLine(0, 1'b1, BIT_CYC);

        // async reset mid-frame
        holdLine(0, 1'b0, BIT_CYC);
        holdLine(0, d7a[0], BIT_CYC);
        holdLine(0, d7a[1], BIT_CYC / 2);
        reset = 1'b0;
        #1;
        checkVal("midRstBusy", busyV[0], 0);
        checkVal("midRstOut", out0, 0);
        checkVal("midRstFlags", {doneV[0], perrV[0], ferrV[0], brkV[0], errV[0]}, 0);
        lineV[0] = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        reset = 1'b1;
        holdLine(0, 1'b1, BIT_CYC);
        sendFrame(0, 32'h7A, 1'b0, 2'b11, 1'b0);
        holdLine(0, 1'b1, 2 * BIT_CYC);
        drain(4 * BIT_CYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
